// File: rtl/avmm_scratch_responder_if.sv
// Avalon-MM bus bundle between a master and avmm_scratch_responder.
// AVMM_SCRATCH_RESPONSE_EN adds the 2-bit response field.
interface avmm_scratch_responder_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic              waitrequest;
  logic [31:0]       readdata;
  logic              readdatavalid;
`ifdef AVMM_SCRATCH_RESPONSE_EN
  logic [1:0]        response;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid, response
  );
  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid, response
  );
`else
  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );
  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
`endif
endinterface

// File: rtl/avmm_scratch_responder.sv
// Avalon-MM pipelined slave over a 32-bit scratch memory: fixed-latency reads,
// byte-enabled writes, read throttling. AVMM_SCRATCH_RESPONSE_EN adds response.
module avmm_scratch_responder #(
  parameter  int DEPTH       = 1024,
  parameter  int ADDR_W      = 10,
  parameter  int READ_LAT    = 2,
  parameter  int MAX_PENDING = 2,
  localparam int PEND_W      = $clog2(MAX_PENDING + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  avmm_scratch_responder_if.slave    bus,
  output logic [PEND_W-1:0]          pending,
  output logic                       protocol_err
);

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [PEND_W-1:0] MAX_P   = PEND_W'(MAX_PENDING);
  localparam int                PRE     = (READ_LAT > 1) ? READ_LAT - 2 : 0;

  logic [31:0] mem [DEPTH];

  logic [READ_LAT-1:0] vld_q, vld_d;
  logic [31:0]         dat_q [READ_LAT];
  logic [31:0]         dat_d [READ_LAT];
`ifdef AVMM_SCRATCH_RESPONSE_EN
  logic [READ_LAT-1:0] err_q, err_d;
`endif
  logic [PEND_W-1:0]   pending_q, pending_d;
  logic                protocol_err_q, protocol_err_d;

  logic        accept, in_range, illegal, wr_en, launch, retire;
  logic [31:0] rd_word;

  // Stall depends on registered state only, so a master may sample it early.
  assign bus.waitrequest = reset || (pending_q == MAX_P);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    accept   = (bus.read || bus.write) && !bus.waitrequest;
    in_range = {1'b0, bus.address} < DEPTH_L;
    illegal  = accept && bus.read && bus.write;
    wr_en    = accept && bus.write && in_range;
`ifdef AVMM_SCRATCH_RESPONSE_EN
    launch   = accept && bus.read;
`else
    launch   = accept && bus.read && !bus.write;
`endif
    rd_word  = 32'h0;
    if (in_range && !bus.write) rd_word = mem[bus.address];

    vld_d[0] = launch;
    dat_d[0] = launch ? rd_word : dat_q[0];
    for (int i = 1; i < READ_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
    end
`ifdef AVMM_SCRATCH_RESPONSE_EN
    err_d[0] = launch ? (!in_range || bus.write) : err_q[0];
    for (int i = 1; i < READ_LAT; i++)
      err_d[i] = vld_q[i-1] ? err_q[i-1] : err_q[i];
`endif

    // A read stops counting as pending in the cycle its response is presented.
    retire         = (READ_LAT == 1) ? launch : vld_q[PRE];
    pending_d      = pending_q + PEND_W'(launch) - PEND_W'(retire);
    protocol_err_d = protocol_err_q || illegal;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (reset) begin
      vld_q          <= '0;
      pending_q      <= '0;
      protocol_err_q <= 1'b0;
      for (int i = 0; i < READ_LAT; i++) dat_q[i] <= 32'h0;
`ifdef AVMM_SCRATCH_RESPONSE_EN
      err_q          <= '0;
`endif
    end else begin
      vld_q          <= vld_d;
      pending_q      <= pending_d;
      protocol_err_q <= protocol_err_d;
      for (int i = 0; i < READ_LAT; i++) dat_q[i] <= dat_d[i];
`ifdef AVMM_SCRATCH_RESPONSE_EN
      err_q          <= err_d;
`endif
    end
  end

  // NOTE: the memory array has no reset; its contents survive reset by design.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.byteenable[b]) mem[bus.address][8*b +: 8] <= bus.writedata[8*b +: 8];
    end
  end

  // Outputs show reset values for the whole reset cycle, hiding in-flight reads.
  assign bus.readdatavalid = !reset && vld_q[READ_LAT-1];
  assign bus.readdata      = reset ? 32'h0 : dat_q[READ_LAT-1];
  assign pending           = reset ? '0 : pending_q;
  assign protocol_err      = !reset && protocol_err_q;
`ifdef AVMM_SCRATCH_RESPONSE_EN
  assign bus.response      = (!reset && err_q[READ_LAT-1]) ? 2'b10 : 2'b00;
`endif

endmodule
